// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM port arbiter.
//   req_id_e  : requester identity (instruction fetch / data load path)
//   rom_rsp_t : one-deep response pipeline entry {valid, tag, err}
//   ROM_IDX_W : word-index width for the default ROM depth
package rom_arb_pkg;

  localparam int unsigned DEPTH_DEFAULT = 128;
  localparam int unsigned ROM_IDX_W     = $clog2(DEPTH_DEFAULT);

  typedef enum logic {
    REQ_IF   = 1'b0,
    REQ_DATA = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e tag;
    logic    err;
  } rom_rsp_t;

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with last-grant register.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_if, req_d   : fetch / data requests
//   gnt_if, gnt_d   : one-hot (or zero) grant, combinational from requests
// Grants are forced low while rst is asserted so every output is quiet in reset.
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_d,
  output logic gnt_if,
  output logic gnt_d
);

  req_id_e last_q;
  req_id_e last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_DATA;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt_if = 1'b0;
    gnt_d  = 1'b0;
    last_d = last_q;
    if (!rst) begin
      // Fetch wins unless data is also asking and fetch had the last grant.
      if (req_if && (!req_d || last_q == REQ_DATA)) begin
        gnt_if = 1'b1;
        last_d = REQ_IF;
      end else if (req_d) begin
        gnt_d  = 1'b1;
        last_d = REQ_DATA;
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares a synchronous-read instruction ROM between instruction fetch (if_*)
// and the data-side load path (d_*). Round-robin grant, word-aligned ROM
// access with range check, and a one-deep tagged response pipeline.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt              : fetch request handshake
//   if_rvalid/if_rdata/if_err          : fetch response (one cycle after grant)
//   d_req/d_addr/d_gnt                 : data request handshake
//   d_rvalid/d_rdata/d_err             : data response (one cycle after grant)
//   rom_en/rom_addr/rom_rdata          : ROM macro interface (rdata one cycle after en)
//   conflict_cnt                       : saturating count of cycles with both requests
// Build option: define ROM_ARB_CONFLICT_CNT_EN to enable conflict_cnt;
// otherwise it is tied to zero.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_W-1:0]        if_rdata,
  output logic                     if_err,
  input  logic                     d_req,
  input  logic [ADDR_W-1:0]        d_addr,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     d_err,
  output logic                     rom_en,
  output logic [$clog2(DEPTH)-1:0] rom_addr,
  input  logic [DATA_W-1:0]        rom_rdata,
  output logic [15:0]              conflict_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [ADDR_W-3:0] word_idx;
  logic              granted;
  logic              in_range;
  rom_rsp_t          rsp_d;
  rom_rsp_t          rsp_q;

  // Byte offsets are deliberately dropped; the data side extracts bytes itself.
  logic unused_byte_off;
  assign unused_byte_off = ^{if_addr[1:0], d_addr[1:0]};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (reset),
    .req_if (if_req),
    .req_d  (d_req),
    .gnt_if (if_gnt),
    .gnt_d  (d_gnt)
  );

  always_comb begin
    granted  = if_gnt | d_gnt;
    word_idx = d_gnt ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
    in_range = (32'(word_idx) < DEPTH);
    rom_en   = granted & in_range;
    rom_addr = in_range ? word_idx[IDX_W-1:0] : '0;

    rsp_d.valid = granted;
    rsp_d.tag   = d_gnt ? REQ_DATA : REQ_IF;
    rsp_d.err   = granted & ~in_range;
  end

  // Reset clears the pipeline entry, so a grant taken just before reset
  // never produces a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  always_comb begin
    if_rvalid = rsp_q.valid & (rsp_q.tag == REQ_IF);
    d_rvalid  = rsp_q.valid & (rsp_q.tag == REQ_DATA);
    if_err    = if_rvalid & rsp_q.err;
    d_err     = d_rvalid & rsp_q.err;
    if_rdata  = (if_rvalid && !rsp_q.err) ? rom_rdata : '0;
    d_rdata   = (d_rvalid && !rsp_q.err) ? rom_rdata : '0;
  end

`ifdef ROM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
    end else if (if_req && d_req && conflict_q != '1) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;
  import rom_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic [11:0] d_addr = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [31:0] rom_rdata = '0;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    req_id_e     tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  logic [31:0] rom [0:127];

  always #5 clk = ~clk;

  rom_port_arbiter #(.DEPTH(128), .ADDR_W(12), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .d_req        (d_req),
    .d_addr       (d_addr),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_rdata    (rom_rdata),
    .conflict_cnt (conflict_cnt)
  );

  // Synchronous-read ROM macro model.
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom[rom_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected response per presented rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid && d_rvalid) begin
        chk("both_rvalid", 32'd1, 32'd0);
      end else if (if_rvalid || d_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", {30'd0, if_rvalid, d_rvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_tag", {31'd0, d_rvalid}, {31'd0, e.tag == REQ_DATA});
          if (e.tag == REQ_IF) begin
            chk("if_rdata", if_rdata, e.data);
            chk("if_err", {31'd0, if_err}, {31'd0, e.err});
            chk("d_rdata_idle", d_rdata, 32'd0);
          end else begin
            chk("d_rdata", d_rdata, e.data);
            chk("d_err", {31'd0, d_err}, {31'd0, e.err});
            chk("if_rdata_idle", if_rdata, 32'd0);
          end
        end
      end
    end
  end

  // One cycle of stimulus: drive at negedge, check combinational grant/ROM
  // outputs, queue the expected response if one is due.
  task automatic cyc(input logic ir, input logic [11:0] ia, input logic dr, input logic [11:0] da,
                     input logic eig, input logic edg, input logic een, input logic [6:0] eaddr,
                     input logic [31:0] edata, input logic eerr, input logic push);
    exp_t e;
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_addr = da;
    #1;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
    chk("rom_en", {31'd0, rom_en}, {31'd0, een});
    if (een) chk("rom_addr", {25'd0, rom_addr}, {25'd0, eaddr});
    if (push && (eig || edg)) begin
      e.tag  = edg ? REQ_DATA : REQ_IF;
      e.data = edata;
      e.err  = eerr;
      sb.push_back(e);
    end
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_outs"}, {22'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, rom_en,
                          rom_addr == 7'd0, if_rdata == 32'd0, d_rdata == 32'd0},
        {29'd0, 3'b111});
    chk({name, "_conflict"}, {16'd0, conflict_cnt}, 32'd0);
  endtask

  initial begin
    rom[0] = 32'h1FC00113;
    for (int unsigned i = 1; i < 128; i++) rom[i] = 32'hC0DE0000 | i;

    // Reset state, with requests pending to show grants are held off.
    if_req = 1'b1; d_req = 1'b1;
    #12;
    check_quiet("reset");
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    reset = 1'b0;

    // First fetch from address 0.
    cyc(1, 12'h000, 0, 12'h000, 1, 0, 1, 7'd0, 32'h1FC00113, 0, 1);
    // Last valid word, out of range, unaligned.
    cyc(0, 12'h000, 1, 12'h1FC, 0, 1, 1, 7'd127, 32'hC0DE007F, 0, 1);
    cyc(0, 12'h000, 1, 12'h200, 0, 1, 0, 7'd0, 32'h00000000, 1, 1);
    cyc(0, 12'h000, 1, 12'h00B, 0, 1, 1, 7'd2, 32'hC0DE0002, 0, 1);
    cyc(0, 12'h000, 0, 12'h000, 0, 0, 0, 7'd0, 32'h0, 0, 0);

    // Contention for 4 cycles: last grant was DATA, so IF, D, IF, D.
    cyc(1, 12'h004, 1, 12'h008, 1, 0, 1, 7'd1, 32'hC0DE0001, 0, 1);
    cyc(1, 12'h004, 1, 12'h008, 0, 1, 1, 7'd2, 32'hC0DE0002, 0, 1);
    cyc(1, 12'h004, 1, 12'h008, 1, 0, 1, 7'd1, 32'hC0DE0001, 0, 1);
    cyc(1, 12'h004, 1, 12'h008, 0, 1, 1, 7'd2, 32'hC0DE0002, 0, 1);
    cyc(0, 12'h000, 0, 12'h000, 0, 0, 0, 7'd0, 32'h0, 0, 0);
`ifdef ROM_ARB_CONFLICT_CNT_EN
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd4);
`else
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif

    // Grant, then reset in the following cycle: the response must vanish.
    cyc(1, 12'h000, 0, 12'h000, 1, 0, 1, 7'd0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    if_req = 1'b1; d_req = 1'b1;
    #1;
    check_quiet("midreset");
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    reset = 1'b0;
    // First contention after reset grants IF.
    cyc(1, 12'h010, 1, 12'h014, 1, 0, 1, 7'd4, 32'hC0DE0004, 0, 1);
    cyc(0, 12'h000, 1, 12'h014, 0, 1, 1, 7'd5, 32'hC0DE0005, 0, 1);

    // Back-to-back fetches 0x000..0x01C.
    cyc(1, 12'h000, 0, 12'h000, 1, 0, 1, 7'd0, 32'h1FC00113, 0, 1);
    for (int unsigned i = 1; i < 8; i++)
      cyc(1, 12'(i * 4), 0, 12'h000, 1, 0, 1, 7'(i), 32'hC0DE0000 | i, 0, 1);
    cyc(0, 12'h000, 0, 12'h000, 0, 0, 0, 7'd0, 32'h0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
